// File: rtl/onehot5_rx_monitor.sv
// Receive-side monitor for the mod-5 one-hot counter bus: encodes the index,
// infers step direction, counts wraps and flags illegal codes or jumps.
//
// state    | meaning
// UNLOCKED | no legal reference sample yet (after reset or an illegal code)
// LOCKED   | tracking; each legal sample is checked against the last index
module onehot5_rx_monitor #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [4:0]        q_in,
  input  logic              clr,
  output logic [2:0]        idx,
  output logic [1:0]        dir,
  output logic              locked,
  output logic              at_max,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err_onehot,
  output logic              err_jump,
  output logic              err_sticky
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_UNK  = 2'b11;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [1:0]        dir_q, dir_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              err_onehot_q, err_onehot_d;
  logic              err_jump_q, err_jump_d;
  logic              err_sticky_q, err_sticky_d;

  logic       legal;
  logic [2:0] n_idx;
  logic [2:0] idx_inc;
  logic [2:0] idx_dec;
  logic       wrap_inc;

  always_comb begin
    legal = 1'b1;
    n_idx = 3'd0;
    case (q_in)
      5'b00001: n_idx = 3'd0;
      5'b00010: n_idx = 3'd1;
      5'b00100: n_idx = 3'd2;
      5'b01000: n_idx = 3'd3;
      5'b10000: n_idx = 3'd4;
      default:  legal = 1'b0;
    endcase
  end

  assign idx_inc = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
  assign idx_dec = (idx_q == 3'd0) ? 3'd4 : idx_q - 3'd1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dir_d        = dir_q;
    err_onehot_d = 1'b0;
    err_jump_d   = 1'b0;
    wrap_inc     = 1'b0;
    if (in_valid) begin
      if (!legal) begin
        err_onehot_d = 1'b1;
        if (state_q == LOCKED) begin
          state_d = UNLOCKED;
          dir_d   = DIR_UNK;
        end
      end else if (state_q == UNLOCKED) begin
        idx_d   = n_idx;
        dir_d   = DIR_UNK;
        state_d = LOCKED;
      end else if (n_idx == idx_q) begin
        dir_d = DIR_HOLD;
      end else if (n_idx == idx_inc) begin
        dir_d    = DIR_UP;
        idx_d    = n_idx;
        wrap_inc = (idx_q == 3'd4);
      end else if (n_idx == idx_dec) begin
        dir_d    = DIR_DOWN;
        idx_d    = n_idx;
        wrap_inc = (idx_q == 3'd0);
      end else begin
        // Non-adjacent legal code: flag it and re-synchronise to the new index.
        err_jump_d = 1'b1;
        dir_d      = DIR_UNK;
        idx_d      = n_idx;
      end
    end

    // An error in the same cycle as clr must leave the sticky flag set.
    if (err_onehot_d || err_jump_d) err_sticky_d = 1'b1;
    else if (clr)                   err_sticky_d = 1'b0;
    else                            err_sticky_d = err_sticky_q;

    if (clr)                                      wrap_d = '0;
    else if (wrap_inc && (wrap_q != {WRAP_W{1'b1}})) wrap_d = wrap_q + 1'b1;
    else                                          wrap_d = wrap_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= UNLOCKED;
      idx_q        <= 3'd0;
      dir_q        <= DIR_UNK;
      wrap_q       <= '0;
      err_onehot_q <= 1'b0;
      err_jump_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dir_q        <= dir_d;
      wrap_q       <= wrap_d;
      err_onehot_q <= err_onehot_d;
      err_jump_q   <= err_jump_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign idx        = idx_q;
  assign dir        = dir_q;
  assign locked     = (state_q == LOCKED);
  assign at_max     = (state_q == LOCKED) && (idx_q == 3'd4);
  assign wrap_cnt   = wrap_q;
  assign err_onehot = err_onehot_q;
  assign err_jump   = err_jump_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_onehot5_rx_monitor.sv
// Bench for onehot5_rx_monitor: directed scenarios plus random traffic, checked
// against a behavioural model; a WRAP_W=2 instance shares the stimulus.
module tb_onehot5_rx_monitor;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] q_in = 5'd0;

  logic [2:0] idx, idx2;
  logic [1:0] dir, dir2;
  logic       locked, locked2, at_max, at_max2;
  logic [7:0] wrap8;
  logic [1:0] wrap2;
  logic       eo, eo2, ej, ej2, st, st2;

  onehot5_rx_monitor #(.WRAP_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .q_in(q_in), .clr(clr),
    .idx(idx), .dir(dir), .locked(locked), .at_max(at_max), .wrap_cnt(wrap8),
    .err_onehot(eo), .err_jump(ej), .err_sticky(st)
  );

  onehot5_rx_monitor #(.WRAP_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .q_in(q_in), .clr(clr),
    .idx(idx2), .dir(dir2), .locked(locked2), .at_max(at_max2), .wrap_cnt(wrap2),
    .err_onehot(eo2), .err_jump(ej2), .err_sticky(st2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_locked;
  int m_idx, m_dir, m_w8, m_w2;
  bit m_eo, m_ej, m_st;

  wire [19:0] act_vec = {idx, dir, locked, at_max, wrap8, wrap2, eo, ej, st};

  function automatic void model_reset();
    m_locked = 0; m_idx = 0; m_dir = 3; m_w8 = 0; m_w2 = 0;
    m_eo = 0; m_ej = 0; m_st = 0;
  endfunction

  function automatic void model_step(bit v, logic [4:0] q, bit c);
    int n, d;
    bit wrapped;
    m_eo = 0; m_ej = 0; wrapped = 0; n = 0;
    if (v) begin
      for (int b = 0; b < 5; b++) if (q[b]) n = b;
      if ($countones(q) != 1) begin
        m_eo = 1;
        if (m_locked) begin m_locked = 0; m_dir = 3; end
      end else if (!m_locked) begin
        m_locked = 1; m_idx = n; m_dir = 3;
      end else begin
        d = (n - m_idx + 5) % 5;
        if (d == 0) m_dir = 0;
        else if (d == 1) begin m_dir = 1; wrapped = (n == 0); end
        else if (d == 4) begin m_dir = 2; wrapped = (n == 4); end
        else begin m_dir = 3; m_ej = 1; end
        m_idx = n;
      end
    end
    if (m_eo || m_ej) m_st = 1;
    else if (c) m_st = 0;
    if (c) begin m_w8 = 0; m_w2 = 0; end
    else if (wrapped) begin
      if (m_w8 < 255) m_w8++;
      if (m_w2 < 3) m_w2++;
    end
  endfunction

  function automatic logic [19:0] exp_vec();
    return {3'(m_idx), 2'(m_dir), m_locked, (m_locked && m_idx == 4),
            8'(m_w8), 2'(m_w2), m_eo, m_ej, m_st};
  endfunction

  task automatic drive(bit v, logic [4:0] q, bit c);
    @(negedge clk);
    in_valid = v; q_in = q; clr = c;
    @(posedge clk);
    if (reset_n) model_step(v, q, c);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act_vec !== 20'b000_11_0_0_00000000_00_0_0_0) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", act_vec, 20'b000_11_0_0_00000000_00_0_0_0);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_up_sequence();
    for (int k = 0; k < 6; k++) begin
      drive(1, 5'b00001 << (k % 5), 0);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL up_seq step %0d: got %h expected %h", k, act_vec, exp_vec());
      end
    end
    checks++;
    if (wrap8 !== 8'd1 || dir !== 2'b01 || idx !== 3'd0) begin
      errors++;
      $display("FAIL up_seq_end: got wrap=%0d dir=%b idx=%0d expected wrap=1 dir=01 idx=0", wrap8, dir, idx);
    end
  endtask

  task automatic test_down_wrap();
    drive(1, 5'b10000, 0);
    drive(1, 5'b01000, 0);
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL down_wrap: got %h expected %h", act_vec, exp_vec());
    end
    checks++;
    if (wrap8 !== 8'd2 || dir !== 2'b10 || idx !== 3'd3) begin
      errors++;
      $display("FAIL down_wrap_vals: got wrap=%0d dir=%b idx=%0d expected wrap=2 dir=10 idx=3", wrap8, dir, idx);
    end
    drive(0, 5'b00100, 0);
    checks++;
    if (act_vec !== exp_vec() || idx !== 3'd3 || dir !== 2'b10) begin
      errors++;
      $display("FAIL invalid_hold: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_onehot_err();
    drive(1, 5'b00100, 0);
    drive(1, 5'b00010, 0);
    drive(1, 5'b00001, 0);
    drive(1, 5'b00011, 0);
    checks++;
    if (act_vec !== exp_vec() || eo !== 1'b1 || locked !== 1'b0 || idx !== 3'd0 || st !== 1'b1) begin
      errors++;
      $display("FAIL onehot_err: got %h expected %h", act_vec, exp_vec());
    end
    drive(1, 5'b00100, 0);
    checks++;
    if (act_vec !== exp_vec() || idx !== 3'd2 || dir !== 2'b11 || ej !== 1'b0 || eo !== 1'b0) begin
      errors++;
      $display("FAIL relock: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_jump();
    drive(1, 5'b00010, 0);
    drive(1, 5'b00001, 0);
    drive(1, 5'b00100, 0);
    checks++;
    if (act_vec !== exp_vec() || ej !== 1'b1 || idx !== 3'd2 || dir !== 2'b11 || locked !== 1'b1) begin
      errors++;
      $display("FAIL jump: got %h expected %h", act_vec, exp_vec());
    end
    drive(1, 5'b01000, 0);
    checks++;
    if (act_vec !== exp_vec() || dir !== 2'b01 || ej !== 1'b0) begin
      errors++;
      $display("FAIL post_jump: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_wrap_sat();
    drive(0, 5'b00000, 1);
    for (int k = 0; k < 26; k++) drive(1, 5'b00001 << ((4 + k) % 5), 0);
    checks++;
    if (act_vec !== exp_vec() || wrap2 !== 2'd3 || wrap8 !== 8'd5 || idx !== 3'd4) begin
      errors++;
      $display("FAIL wrap_sat: got %h (wrap2=%0d) expected %h (wrap2=3)", act_vec, wrap2, exp_vec());
    end
    drive(1, 5'b00001, 1);
    checks++;
    if (act_vec !== exp_vec() || wrap2 !== 2'd0 || wrap8 !== 8'd0 || st !== 1'b0) begin
      errors++;
      $display("FAIL clr_vs_wrap: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_clr_vs_err();
    drive(1, 5'b11000, 1);
    checks++;
    if (act_vec !== exp_vec() || eo !== 1'b1 || st !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_err: got %h expected %h", act_vec, exp_vec());
    end
    drive(0, 5'b00000, 0);
    checks++;
    if (act_vec !== exp_vec() || eo !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse_width: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    drive(1, 5'b00001, 0);
    drive(1, 5'b00010, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act_vec !== exp_vec() || act_vec !== 20'b000_11_0_0_00000000_00_0_0_0) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", act_vec, exp_vec());
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 5'b01000, 0);
    checks++;
    if (act_vec !== exp_vec() || idx !== 3'd3 || locked !== 1'b1 || eo !== 1'b0 || ej !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_lock: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    logic [4:0] q;
    bit v, c;
    int r;
    int steps[3] = '{0, 1, 4};
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      q = 5'b00001 << ((m_idx + steps[r % 3]) % 5);
      else if (r <= 7) q = 5'b00001 << $urandom_range(0, 4);
      else             q = 5'($urandom_range(0, 31));
      v = ($urandom_range(0, 7) != 0);
      c = ($urandom_range(0, 15) == 0);
      drive(v, q, c);
      checks++;
      if (act_vec !== exp_vec() || wrap2 !== 2'(m_w2)) begin
        errors++;
        $display("FAIL random step %0d q=%b v=%0b c=%0b: got %h expected %h", i, q, v, c, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_sequence();
    test_down_wrap();
    test_onehot_err();
    test_jump();
    test_wrap_sat();
    test_clr_vs_err();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
